nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder built around one 4-bit ripple-adder slice.
- Accepts wide operands over a valid/ready handshake and feeds the slice one nibble per cycle, LSB first.
- Chains the carry through a register and assembles the sum nibbles into a wide result, presented on an output handshake.
- Sits between operand sources and the 4-bit adder slice, as both its upstream sequencer and its downstream collector.

---
 rtl/nibble_serial_adder_pkg.sv | 16 +
 rtl/nibble_serial_adder_add4.sv | 24 ++
 rtl/nibble_serial_adder.sv | 129 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Ceiling log2, used to size the nibble index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_add4.sv
// nibble_add4: combinational 4-bit ripple-carry adder slice; c3 is the carry into bit 3.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  always_comb begin
    logic c;
    s  = '0;
    c3 = 1'b0;
    c  = ci;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) c3 = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a 4-bit slice, LSB first.
// Optional signed-overflow output enabled by defining OVERFLOW_FLAG_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [NIB_W-1:0] a_nib, b_nib, slice_s;
  logic             slice_co, slice_c3;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib = a_q[n*NIB_W +: NIB_W];
        b_nib = b_q[n*NIB_W +: NIB_W];
      end
    end
  end

  nibble_add4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  wire last_step = (idx_q == IDX_W'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= a;
          b_q        <= b;
          carry_q    <= cin;
          idx_q      <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= RUN;
        end
        RUN: begin
          for (int n = 0; n < NIB; n++)
            if (idx_q == IDX_W'(n)) sum_q[n*NIB_W +: NIB_W] <= slice_s;
          carry_q <= slice_co;
          if (last_step) begin
            cout_q      <= slice_co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        // No accept here: IDLE must be re-entered first, costing one cycle.
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf_q <= 1'b0;
    else if (state_q == RUN && last_step) ovf_q <= slice_c3 ^ slice_co;
  end
  assign ovf = ovf_q;
`else
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk, rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c);
    logic [W:0] r;
    r = ref_add(x, y, c);
    chk({tag, ".sum"}, 32'(sum), 32'(r[W-1:0]));
    chk({tag, ".cout"}, 32'(cout), 32'(r[W]));
`ifdef OVERFLOW_FLAG_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
  endtask

  // One operation; hold = cycles of out_ready=0 backpressure with junk operands offered.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input int hold);
    int cyc;
    logic [W:0] r;
    r = ref_add(x, y, c);
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(NIB));
    check_result(tag, x, y, c);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, ".bp_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".bp_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ".bp_sum"}, 32'(sum), 32'(r[W-1:0]));
      chk({tag, ".bp_cout"}, 32'(cout), 32'(r[W]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W:0] exp_q[$];
    logic [W:0] e;
    int pushed, got, last_cyc, cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst.ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    do_op("basic",   16'h1234, 16'h4321, 1'b0, 0);
    do_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("cin",     16'h0FFF, 16'h0000, 1'b1, 0);
    do_op("sovf",    16'h7FFF, 16'h0001, 1'b0, 0);
    do_op("zerocin", 16'h0000, 16'h0000, 1'b1, 0);
    do_op("bp",      16'hA5C3, 16'h6B2E, 1'b1, 5);
    do_op("post_bp", 16'h8000, 16'h8000, 1'b0, 0);

    // Reset mid-RUN at idx=2.
    @(negedge clk);
    a = 16'hBEEF; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.sum", 32'(sum), 32'd0);
    chk("midrst.cout", 32'(cout), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op("after_rst", 16'h00FF, 16'h0F01, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    // Back-to-back: in_valid and out_ready held high, three operations.
    pushed = 0; got = 0; last_cyc = -1; cyc = 0;
    out_ready = 1'b1;
    while (got < 3 && cyc < 100) begin
      @(negedge clk);
      if (in_ready) begin
        if (pushed < 3) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
          exp_q.push_back(ref_add(a, b, cin));
          pushed++;
        end else in_valid = 1'b0;
      end else begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("b2b.extra", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("b2b.sum", 32'(sum), 32'(e[W-1:0]));
          chk("b2b.cout", 32'(cout), 32'(e[W]));
        end
        if (last_cyc >= 0) chk("b2b.period", 32'(cyc - last_cyc), 32'(NIB + 2));
        last_cyc = cyc;
        got++;
      end
    end
    chk("b2b.count", 32'(got), 32'd3);
    in_valid = 1'b0;
    repeat (NIB + 3) @(posedge clk);
    #1;
    chk("b2b.no_dup", 32'(out_valid), 32'd0);
    chk("b2b.idle", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
